// File: rtl/baud_autodetect.sv
// Owns the UART baud-generator divisor: loaded by CPU write or measured from a 0x55 sync
// character (eight half-cycle segments of the raw rx line averaged into one divisor).
module baud_autodetect #(
    parameter int CNT_W        = 28,
    parameter int DEFAULT_DVSR = 325,
    parameter int TIMEOUT_CYC  = 2**24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             start,
    input  logic             wr_en,
    input  logic [CNT_W-8:0] wr_dvsr,
    output logic [CNT_W-8:0] dvsr,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int DW = CNT_W - 7;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FALL, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [DW-1:0]    dvsr_q, dvsr_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] seg_q, seg_d, tot_q, tot_d, s0_q, s0_d;
    logic [2:0]       ecnt_q, ecnt_d;

    logic             edge_det, fall_det, in_range;
    logic [CNT_W:0]   tot_sum, s0_hi, s0_lo, q_wide;

    always_comb begin
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        edge_det  = rx_s2_q ^ rx_prev_q;
        fall_det  = rx_prev_q & ~rx_s2_q;

        // Segment arithmetic is one bit wider than the counters so it never wraps.
        tot_sum  = {1'b0, tot_q} + {1'b0, seg_q};
        s0_lo    = {2'b00, s0_q[CNT_W-1:1]};
        s0_hi    = {1'b0, s0_q} + s0_lo;
        in_range = ({1'b0, seg_q} >= s0_lo) && ({1'b0, seg_q} <= s0_hi);
        q_wide   = (tot_sum + (CNT_W+1)'(64)) >> 7;

        state_d = state_q;
        dvsr_d  = dvsr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tot_d   = tot_q;
        s0_d    = s0_q;
        ecnt_d  = ecnt_q;
        seg_d   = edge_det ? CNT_W'(1) :
                  (state_q == MEASURE) ? seg_q + CNT_W'(1) : seg_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (fall_det) begin
                    tot_d   = '0;
                    ecnt_d  = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    tot_d  = tot_sum[CNT_W-1:0];
                    ecnt_d = ecnt_q + 3'd1;
                    if (ecnt_q == 3'd0) s0_d = seg_q;
                    if (ecnt_q != 3'd0 && !in_range) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (ecnt_q == 3'd7) begin
                        state_d = IDLE;
                        if (q_wide == '0) begin
                            err_d = 1'b1;
                        end else begin
                            dvsr_d = DW'(q_wide - (CNT_W+1)'(1));
                            done_d = 1'b1;
                        end
                    end
                end else if (seg_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A CPU write overrides everything, including a result landing this cycle.
        if (wr_en) begin
            dvsr_d  = wr_dvsr;
            state_d = IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        busy_d = (state_d == WAIT_FALL) || (state_d == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            dvsr_q    <= DW'(DEFAULT_DVSR);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            dvsr_q    <= dvsr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Measurement datapath is always (re)initialised on entry to MEASURE.
    always_ff @(posedge clk) begin
        seg_q  <= seg_d;
        tot_q  <= tot_d;
        s0_q   <= s0_d;
        ecnt_q <= ecnt_d;
    end

    assign dvsr = dvsr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_baud_autodetect.sv
// Directed and randomized bench for baud_autodetect with a segment-level reference model.
module tb_baud_autodetect;
    logic        clk = 1'b0;
    logic        reset, rx, start, wr_en;
    logic [20:0] wr_dvsr;
    logic [20:0] dvsr, dvsr_t;
    logic        busy, done, err, busy_t, done_t, err_t;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int done_n, done_at, err_n, err_at, err_t_n, err_t_at;
    int seg_len[8];
    int chg_at[9];
    int exp_dvsr;

    baud_autodetect dut (
        .clk(clk), .reset(reset), .rx(rx), .start(start), .wr_en(wr_en),
        .wr_dvsr(wr_dvsr), .dvsr(dvsr), .busy(busy), .done(done), .err(err)
    );

    baud_autodetect #(.TIMEOUT_CYC(1000)) dut_to (
        .clk(clk), .reset(reset), .rx(rx), .start(start), .wr_en(wr_en),
        .wr_dvsr(wr_dvsr), .dvsr(dvsr_t), .busy(busy_t), .done(done_t), .err(err_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin done_n++; done_at = cyc; end
        if (err) begin err_n++; err_at = cyc; end
        if (err_t) begin err_t_n++; err_t_at = cyc; end
        n_chk++;
        assert (!(done && err)) else begin
            n_fail++;
            $error("FAIL done_err_excl observed done=%b err=%b required not both", done, err);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        done_n = 0; err_n = 0; err_t_n = 0;
        done_at = -1; err_at = -1; err_t_at = -1;
    endtask

    task automatic wr(input int v);
        wr_dvsr = 21'(v); wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step(4);
    endtask

    // Drives the start-bit fall, eight toggles spaced by seg_len, then a high stop level.
    task automatic send_frame();
        rx = 1'b0;
        chg_at[0] = cyc;
        for (int i = 0; i < 8; i++) begin
            step(seg_len[i]);
            rx = ~rx;
            chg_at[i+1] = cyc;
        end
        step(seg_len[7]);
        rx = 1'b1;
        step(20);
    endtask

    // Outcome of one measurement from the list of segment lengths alone.
    function automatic void ref_model(input int lens[8], output bit ok, output int ev_edge,
                                      output int q);
        int s0;
        longint t;
        s0 = lens[0]; t = 0; ok = 1'b1; ev_edge = 8; q = 0;
        for (int i = 0; i < 8; i++) begin
            t += lens[i];
            if (i > 0 && (lens[i] < s0 / 2 || lens[i] > s0 + s0 / 2)) begin
                ok = 1'b0; ev_edge = i + 1;
                return;
            end
        end
        q = int'((t + 64) / 128);
        if (q == 0) ok = 1'b0;
    endfunction

    task automatic run_frame(input string tag);
        bit ok;
        int ev, q;
        clear_events();
        pulse_start();
        check({tag, "_busy_wait"}, busy, 1);
        send_frame();
        ref_model(seg_len, ok, ev, q);
        if (ok) begin
            exp_dvsr = q - 1;
            check({tag, "_done_cnt"}, done_n, 1);
            check({tag, "_done_cyc"}, done_at, chg_at[8] + 3);
            check({tag, "_err_cnt"}, err_n, 0);
        end else begin
            check({tag, "_err_cnt"}, err_n, 1);
            check({tag, "_err_cyc"}, err_at, chg_at[ev] + 3);
            check({tag, "_done_cnt"}, done_n, 0);
        end
        check({tag, "_dvsr"}, dvsr, exp_dvsr);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int p, c0;
        reset = 1'b1; rx = 1'b1; start = 1'b0; wr_en = 1'b0; wr_dvsr = '0;
        exp_dvsr = 325;
        step(3);
        reset = 1'b0;
        check("rst_dvsr", dvsr, 325);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        for (int i = 0; i < 8; i++) seg_len[i] = 128;
        run_frame("fast");
        check("fast_dvsr7", dvsr, 7);

        wr(0);
        exp_dvsr = 0;
        check("preload0", dvsr, 0);
        for (int i = 0; i < 8; i++) seg_len[i] = 5208;
        run_frame("b9600");
        check("b9600_dvsr325", dvsr, 325);

        seg_len = '{128, 512, 512, 128, 128, 128, 128, 128};
        run_frame("bad0f");

        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(40, 150));
            for (int i = 0; i < 8; i++) seg_len[i] = p - p / 4 + int'($urandom_range(0, p / 2));
            if ($urandom % 3 == 0) seg_len[$urandom_range(1, 7)] = ($urandom % 2 == 1) ? 2 * p : p / 3;
            run_frame($sformatf("rnd%0d", r));
        end

        // Abort by CPU write part-way through a measurement.
        clear_events();
        pulse_start();
        rx = 1'b0;
        for (int i = 0; i < 2; i++) begin step(128); rx = ~rx; end
        step(20);
        check("abort_busy_pre", busy, 1);
        wr(100);
        exp_dvsr = 100;
        check("abort_dvsr", dvsr, 100);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin step(128); rx = ~rx; end
        step(128); rx = 1'b1; step(20);
        check("abort_done_cnt", done_n, 0);
        check("abort_err_cnt", err_n, 0);
        check("abort_dvsr_end", dvsr, 100);

        // Simultaneous start and write in IDLE.
        start = 1'b1; wr_en = 1'b1; wr_dvsr = 21'd55;
        step();
        start = 1'b0; wr_en = 1'b0;
        check("startwr_dvsr", dvsr, 55);
        check("startwr_busy", busy, 0);
        step(3);
        check("startwr_busy_later", busy, 0);

        // Timeout on the short-timeout instance, then reset the main one mid-measure.
        wr(77);
        check("pre_to_dvsr", dvsr, 77);
        clear_events();
        pulse_start();
        rx = 1'b0;
        c0 = cyc;
        step(1100);
        check("to_err_cnt", err_t_n, 1);
        check("to_err_cyc", err_t_at, c0 + 1002);
        check("to_busy", busy_t, 0);
        check("to_main_busy", busy, 1);
        reset = 1'b1; rx = 1'b1;
        step();
        check("midrst_dvsr", dvsr, 325);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        reset = 1'b0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
